// File: rtl/sha256_pkg.sv
`default_nettype none
// ==== sha256_pkg : shared widths, padding constant and FSM states for the SHA-256 padder ====
// rev 1.0
package sha256_pkg;

  localparam int WORD_W  = 32;
  localparam int BLOCK_W = 512;
  localparam int LEN_W   = 64;
  localparam int NWORDS  = BLOCK_W / WORD_W;

  localparam logic [WORD_W-1:0] PAD_WORD = 32'h80000000;

  typedef enum logic [1:0] {
    ST_ABSORB = 2'd0,
    ST_PAD    = 2'd1,
    ST_OUT    = 2'd2
  } state_e;

  // Byte counts above 4 on the final word are treated as a full word.
  function automatic logic [2:0] clamp_nbytes(input logic [2:0] n);
    return (n > 3'd4) ? 3'd4 : n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sha256_pad_word.sv
`default_nettype none
// ==== sha256_pad_word : keeps the valid leading bytes of the final word and appends 0x80 ====
// rev 1.0
module sha256_pad_word
  import sha256_pkg::*;
(
  input  logic [WORD_W-1:0] in_data,
  input  logic [2:0]        k,
  output logic [WORD_W-1:0] word
);

  always_comb begin
    word = in_data;
    case (clamp_nbytes(k))
      3'd0:    word = PAD_WORD;
      3'd1:    word = {in_data[31:24], 8'h80, 16'h0000};
      3'd2:    word = {in_data[31:16], 8'h80, 8'h00};
      3'd3:    word = {in_data[31:8], 8'h80};
      default: word = in_data;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/sha256_padder.sv
`default_nettype none
// ==== sha256_padder : FIPS 180-4 message padding and 512-bit blocking ahead of the schedule ====
// rev 1.0
module sha256_padder
  import sha256_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WORD_W-1:0]  in_data,
  input  logic               in_last,
  input  logic [2:0]         in_nbytes,
  output logic [BLOCK_W-1:0] block,
  output logic               block_valid,
  input  logic               block_ready,
  output logic               block_first,
  output logic               block_last
);

  state_e            state_q;
  logic [WORD_W-1:0] buf_q [NWORDS];
  logic [4:0]        idx_q;
  logic [LEN_W-1:0]  bitlen_q;
  logic              pend80_q;
  logic              first_q;
  logic              final_q;
  logic              from_pad_q;
  logic              in_ready_q;
  logic              block_valid_q;

  logic [2:0]        nbytes_d;
  logic [3:0]        slot_d;
  logic              accept_d;
  logic [WORD_W-1:0] last_word_d;

  assign nbytes_d = clamp_nbytes(in_nbytes);
  assign slot_d   = idx_q[3:0];
  assign accept_d = in_valid && in_ready_q;

  sha256_pad_word u_pad_word (
    .in_data (in_data),
    .k       (in_nbytes),
    .word    (last_word_d)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_ABSORB;
      for (int i = 0; i < NWORDS; i++) buf_q[i] <= '0;
      idx_q         <= '0;
      bitlen_q      <= '0;
      pend80_q      <= 1'b0;
      first_q       <= 1'b1;
      final_q       <= 1'b0;
      from_pad_q    <= 1'b0;
      in_ready_q    <= 1'b0;
      block_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_ABSORB: begin
          in_ready_q <= 1'b1;
          if (accept_d) begin
            idx_q <= idx_q + 5'd1;
            if (in_last) begin
              buf_q[slot_d] <= last_word_d;
              // A full final word leaves no room for 0x80; PAD writes it as the next word.
              pend80_q      <= (nbytes_d == 3'd4);
              bitlen_q      <= bitlen_q + LEN_W'({nbytes_d, 3'b000});
              in_ready_q    <= 1'b0;
              state_q       <= ST_PAD;
            end else begin
              buf_q[slot_d] <= in_data;
              bitlen_q      <= bitlen_q + LEN_W'(WORD_W);
              if (slot_d == 4'd15) begin
                in_ready_q    <= 1'b0;
                block_valid_q <= 1'b1;
                final_q       <= 1'b0;
                from_pad_q    <= 1'b0;
                state_q       <= ST_OUT;
              end
            end
          end
        end

        ST_PAD: begin
          if (idx_q == 5'd16) begin
            block_valid_q <= 1'b1;
            final_q       <= 1'b0;
            from_pad_q    <= 1'b1;
            state_q       <= ST_OUT;
          end else if (idx_q == 5'd14 && !pend80_q) begin
            buf_q[14]     <= bitlen_q[LEN_W-1:WORD_W];
            buf_q[15]     <= bitlen_q[WORD_W-1:0];
            block_valid_q <= 1'b1;
            final_q       <= 1'b1;
            from_pad_q    <= 1'b1;
            state_q       <= ST_OUT;
          end else begin
            buf_q[slot_d] <= pend80_q ? PAD_WORD : '0;
            pend80_q      <= 1'b0;
            idx_q         <= idx_q + 5'd1;
          end
        end

        ST_OUT: begin
          if (block_ready) begin
            block_valid_q <= 1'b0;
            idx_q         <= '0;
            final_q       <= 1'b0;
            if (final_q) begin
              bitlen_q   <= '0;
              first_q    <= 1'b1;
              in_ready_q <= 1'b1;
              state_q    <= ST_ABSORB;
            end else begin
              first_q <= 1'b0;
              if (from_pad_q) begin
                state_q <= ST_PAD;
              end else begin
                in_ready_q <= 1'b1;
                state_q    <= ST_ABSORB;
              end
            end
          end
        end

        default: state_q <= ST_ABSORB;
      endcase
    end
  end

  for (genvar g = 0; g < NWORDS; g++) begin : g_pack
    assign block[BLOCK_W-1-WORD_W*g -: WORD_W] = buf_q[g];
  end

  assign in_ready    = in_ready_q;
  assign block_valid = block_valid_q;
  assign block_first = first_q;
  assign block_last  = final_q;

endmodule
`default_nettype wire

// File: tb/tb_sha256_padder.sv
`default_nettype none
// ==== tb_sha256_padder : randomized messages checked against a byte-level padding model ====
// rev 1.0
module tb_sha256_padder;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [31:0]  in_data = '0;
  logic         in_last = 1'b0;
  logic [2:0]   in_nbytes = '0;
  logic [511:0] block;
  logic         block_valid;
  logic         block_ready;
  logic         block_first;
  logic         block_last;

  always #5 clk = ~clk;

  sha256_padder dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_last     (in_last),
    .in_nbytes   (in_nbytes),
    .block       (block),
    .block_valid (block_valid),
    .block_ready (block_ready),
    .block_first (block_first),
    .block_last  (block_last)
  );

  typedef byte unsigned bq_t[$];
  typedef struct {
    logic [511:0] blk;
    logic         first;
    logic         last;
  } exp_t;

  int   total = 0;
  int   bad = 0;
  int   rdy_mode = 1;
  exp_t exp_q[$];
  exp_t seen_q[$];

  task automatic check(input string nm, input logic [511:0] act, input logic [511:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  task automatic chk_b(input string nm, input logic act, input logic req);
    check(nm, {511'd0, act}, {511'd0, req});
  endtask

  task automatic chk_i(input string nm, input int act, input int req);
    check(nm, {480'd0, act}, {480'd0, req});
  endtask

  // Padding model: bytes, 0x80, zeros to 56 mod 64, then the 64-bit bit length.
  task automatic model_blocks(input bq_t msg, output exp_t out[$]);
    bq_t         p;
    logic [63:0] len;
    int          nb;
    exp_t        e;
    p   = msg;
    len = 64'(msg.size()) * 64'd8;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    for (int i = 7; i >= 0; i--) p.push_back(len[8*i +: 8]);
    out = {};
    nb  = p.size() / 64;
    for (int b = 0; b < nb; b++) begin
      e.blk = '0;
      for (int j = 0; j < 64; j++) e.blk[511-8*j -: 8] = p[64*b+j];
      e.first = (b == 0);
      e.last  = (b == nb - 1);
      out.push_back(e);
    end
  endtask

  task automatic push_model(input bq_t msg);
    exp_t blks[$];
    model_blocks(msg, blks);
    foreach (blks[i]) exp_q.push_back(blks[i]);
  endtask

  initial begin
    block_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0:       block_ready = ($urandom_range(0, 3) != 0);
        1:       block_ready = 1'b1;
        default: block_ready = 1'b0;
      endcase
    end
  end

  // Compare process: scoreboard on every handshake, stability while stalled.
  initial begin
    logic         pv_hold;
    logic [511:0] pv_blk;
    logic         pv_first;
    logic         pv_last;
    exp_t         e;
    pv_hold = 1'b0;
    pv_blk = '0;
    pv_first = 1'b0;
    pv_last = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        pv_hold = 1'b0;
      end else begin
        if (pv_hold) begin
          chk_b("hold_valid", block_valid, 1'b1);
          check("hold_block", block, pv_blk);
          chk_b("hold_first", block_first, pv_first);
          chk_b("hold_last", block_last, pv_last);
        end
        if (block_valid) chk_b("in_ready_while_out", in_ready, 1'b0);
        if (block_valid && block_ready) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_block: got block %0h, want none", block);
          end else begin
            e = exp_q.pop_front();
            check("block_data", block, e.blk);
            chk_b("block_first", block_first, e.first);
            chk_b("block_last", block_last, e.last);
          end
          e.blk = block;
          e.first = block_first;
          e.last = block_last;
          seen_q.push_back(e);
        end
        pv_hold  = block_valid && !block_ready;
        pv_blk   = block;
        pv_first = block_first;
        pv_last  = block_last;
      end
    end
  end

  task automatic drive_idle();
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    in_data   = $urandom;
    in_last   = 1'($urandom_range(0, 1));
    in_nbytes = 3'($urandom_range(0, 7));
  endtask

  task automatic send_word(input logic [31:0] d, input logic l, input logic [2:0] nb, output bit ok);
    @(posedge clk);
    #1;
    in_valid  = 1'b1;
    in_data   = d;
    in_last   = l;
    in_nbytes = nb;
    ok = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL in_ready_timeout: got in_ready 0 for 400 cycles, want 1");
    end
  endtask

  task automatic send_msg(input bq_t msg, input bit extra_empty, input bit gaps);
    int          n;
    int          nw;
    int          k;
    bit          ee;
    bit          ok;
    logic        l;
    logic [2:0]  nb;
    logic [31:0] d;
    n  = msg.size();
    nw = (n == 0) ? 1 : (n + 3) / 4;
    ee = extra_empty && (n > 0) && (n % 4 == 0);
    push_model(msg);
    for (int w = 0; w < nw; w++) begin
      if (gaps) repeat ($urandom_range(0, 2)) drive_idle();
      d = $urandom;
      k = n - 4 * w;
      if (k > 4) k = 4;
      for (int b = 0; b < k; b++) d[31-8*b -: 8] = msg[4*w+b];
      l  = (w == nw - 1) && !ee;
      nb = l ? 3'(k) : 3'($urandom_range(0, 7));
      if (l && k == 4) nb = 3'($urandom_range(4, 7));
      send_word(d, l, nb, ok);
      if (!ok) return;
    end
    if (ee) send_word($urandom, 1'b1, 3'd0, ok);
    drive_idle();
  endtask

  task automatic measure_latency(output int cnt);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!block_valid && cnt < 100);
  endtask

  task automatic wait_seen(input int n, input string nm);
    int c;
    c = 0;
    while (seen_q.size() < n && c < 500) begin
      @(negedge clk);
      c++;
    end
    chk_i({nm, "_count"}, seen_q.size(), n);
  endtask

  task automatic check_reset_values(input string nm);
    chk_b({nm, "_in_ready"}, in_ready, 1'b0);
    chk_b({nm, "_valid"}, block_valid, 1'b0);
    chk_b({nm, "_first"}, block_first, 1'b1);
    chk_b({nm, "_last"}, block_last, 1'b0);
    check({nm, "_block"}, block, '0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, want $finish");
    $fatal(1);
  end

  initial begin
    bq_t         m;
    bq_t         abc;
    exp_t        pin[$];
    int          lat;
    bit          ok;
    logic [31:0] d;
    int          lens_b[8] = '{0, 55, 56, 57, 60, 63, 64, 119};
    int          len;

    abc = '{8'h61, 8'h62, 8'h63};

    // Model pins against hand-computed blocks.
    model_blocks(abc, pin);
    chk_i("model_abc_n", pin.size(), 1);
    check("model_abc_blk", pin[0].blk, {32'h61626380, 448'h0, 32'h00000018});
    m = {};
    for (int i = 0; i < 56; i++) m.push_back(8'(i));
    model_blocks(m, pin);
    chk_i("model_56_n", pin.size(), 2);
    check("model_56_blk2", pin[1].blk, {480'h0, 32'h000001C0});

    repeat (2) @(negedge clk);
    check_reset_values("reset");
    #1 reset_n = 1'b1;

    // abc
    rdy_mode = 1;
    seen_q = {};
    send_msg(abc, 1'b0, 1'b0);
    measure_latency(lat);
    chk_i("abc_latency", lat, 15);
    wait_seen(1, "abc");
    if (seen_q.size() >= 1) begin
      check("abc_block", seen_q[0].blk, {32'h61626380, 448'h0, 32'h00000018});
      chk_b("abc_first", seen_q[0].first, 1'b1);
      chk_b("abc_last", seen_q[0].last, 1'b1);
    end

    // empty message
    seen_q = {};
    m = {};
    send_msg(m, 1'b0, 1'b0);
    measure_latency(lat);
    chk_i("empty_latency", lat, 15);
    wait_seen(1, "empty");
    if (seen_q.size() >= 1) begin
      check("empty_block", seen_q[0].blk, {32'h80000000, 480'h0});
      chk_b("empty_first", seen_q[0].first, 1'b1);
    end

    // 56 bytes
    seen_q = {};
    m = {};
    for (int i = 0; i < 56; i++) m.push_back(8'($urandom));
    send_msg(m, 1'b0, 1'b0);
    wait_seen(2, "b56");
    if (seen_q.size() >= 2) begin
      check("b56_tail", {448'h0, seen_q[0].blk[63:0]}, {448'h0, 64'h80000000_00000000});
      chk_b("b56_last1", seen_q[0].last, 1'b0);
      check("b56_block2", seen_q[1].blk, {480'h0, 32'h000001C0});
      chk_b("b56_first2", seen_q[1].first, 1'b0);
    end

    // 64 bytes as 16 full words plus an empty final word
    seen_q = {};
    m = {};
    for (int i = 0; i < 64; i++) m.push_back(8'($urandom));
    push_model(m);
    for (int w = 0; w < 16; w++) begin
      d = {m[4*w], m[4*w+1], m[4*w+2], m[4*w+3]};
      send_word(d, 1'b0, 3'($urandom_range(0, 7)), ok);
    end
    drive_idle();
    measure_latency(lat);
    chk_i("data_latency", lat, 1);
    send_word($urandom, 1'b1, 3'd0, ok);
    drive_idle();
    wait_seen(2, "b64");
    if (seen_q.size() >= 2) begin
      chk_b("b64_first1", seen_q[0].first, 1'b1);
      check("b64_block2", seen_q[1].blk, {32'h80000000, 448'h0, 32'h00000200});
      chk_b("b64_last2", seen_q[1].last, 1'b1);
    end

    // Backpressure
    rdy_mode = 2;
    send_msg(abc, 1'b0, 1'b0);
    lat = 0;
    while (!block_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk_b("bp_valid", block_valid, 1'b1);
      chk_b("bp_in_ready", in_ready, 1'b0);
    end
    @(posedge clk);
    #1 rdy_mode = 1;
    @(negedge clk);
    chk_b("bp_release_valid", block_valid, 1'b1);
    @(negedge clk);
    chk_b("bp_after_valid", block_valid, 1'b0);
    chk_b("bp_after_in_ready", in_ready, 1'b1);

    // Reset after 5 words, then abc
    seen_q = {};
    for (int w = 0; w < 5; w++) send_word($urandom, 1'b0, 3'd4, ok);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    reset_n  = 1'b0;
    @(negedge clk);
    check_reset_values("midreset");
    repeat (2) @(negedge clk);
    #1 reset_n = 1'b1;
    send_msg(abc, 1'b0, 1'b0);
    wait_seen(1, "rst_abc");
    if (seen_q.size() >= 1) begin
      check("rst_abc_block", seen_q[0].blk, {32'h61626380, 448'h0, 32'h00000018});
      chk_b("rst_abc_first", seen_q[0].first, 1'b1);
    end

    // Randomized messages with random gaps and downstream stalls
    rdy_mode = 0;
    for (int t = 0; t < 25; t++) begin
      len = ($urandom_range(0, 3) == 0) ? lens_b[$urandom_range(0, 7)] : int'($urandom_range(1, 140));
      m = {};
      for (int i = 0; i < len; i++) m.push_back(8'($urandom));
      send_msg(m, 1'($urandom_range(0, 1)), 1'b1);
    end

    rdy_mode = 1;
    lat = 0;
    while (exp_q.size() != 0 && lat < 2000) begin
      @(negedge clk);
      lat++;
    end
    chk_i("drain", exp_q.size(), 0);
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
